// File: rtl/midi_pkg.sv
// Shared MIDI definitions used by both the receive-store and transmit-fetch blocks.
package midi_pkg;

    localparam logic [7:0] MIDI_ACTIVE_SENSE = 8'hFE;
    localparam logic [7:0] DROP_COUNT_MAX    = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HOLD    = 2'd1,
        S_BLOCKED = 2'd2
    } rx_state_t;

endpackage

// File: rtl/midi_alive_timer.sv
// Active-sensing watchdog: arm raises link_alive, kick restarts the count,
// and link_alive falls after TIMEOUT_CYCLES cycles with no kick.
module midi_alive_timer #(
    parameter int TIMEOUT_CYCLES = 9600000
) (
    input  logic clk,
    input  logic rst,
    input  logic kick,
    input  logic arm,
    input  logic clear,
    output logic link_alive
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count      <= '0;
            link_alive <= 1'b0;
        end else if (kick) begin
            count <= '0;
            if (arm) begin
                link_alive <= 1'b1;
            end
        end else if (link_alive) begin
            if (count == LAST_COUNT) begin
                count      <= '0;
                link_alive <= 1'b0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/midi_rx_store.sv
// Buffers UART-received MIDI bytes into a write-side FIFO through a one-byte
// hold register, tracking active-sensing keep-alive and lost bytes.
module midi_rx_store
    import midi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 9600000,
    parameter int PASS_FE        = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       midi_clk_locked,
    input  logic       uart_valid,
    input  logic [7:0] uart_data,
    input  logic       uart_frame_err,
    input  logic       fifo_full,
    input  logic       fifo_wr_rst_busy,
    output logic       fifo_wr,
    output logic [7:0] fifo_in,
    output logic       link_alive,
    output logic       overflow,
    input  logic       overflow_clr,
    output logic [7:0] drop_count
);

    rx_state_t  state;
    logic [7:0] hold;
    logic       blocked;
    logic       accepted;
    logic       is_fe;
    logic       storable;
    logic       drop_event;

    assign blocked    = fifo_wr_rst_busy || !midi_clk_locked;
    assign accepted   = uart_valid && !uart_frame_err &&
                        (state == S_IDLE || state == S_HOLD);
    assign is_fe      = (uart_data == MIDI_ACTIVE_SENSE);
    assign storable   = accepted && (!is_fe || (PASS_FE != 0));
    assign drop_event = (state == S_HOLD) && fifo_full && storable;

    // Write is gated by the blocking conditions too, so a FIFO entering reset
    // never sees a strobe even in the cycle before the state changes.
    assign fifo_wr = (state == S_HOLD) && !fifo_full && !blocked;
    assign fifo_in = hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            hold  <= '0;
        end else if (blocked) begin
            state <= S_BLOCKED;
            hold  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (storable) begin
                        hold  <= uart_data;
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!fifo_full) begin
                        if (storable) begin
                            hold <= uart_data;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Clear wins over a same-cycle drop; that drop is simply not recorded.
    always_ff @(posedge clk) begin
        if (rst || overflow_clr) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop_event) begin
            overflow <= 1'b1;
            if (drop_count != DROP_COUNT_MAX) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    midi_alive_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_alive_timer (
        .clk       (clk),
        .rst       (rst),
        .kick      (accepted),
        .arm       (accepted && is_fe),
        .clear     (!midi_clk_locked),
        .link_alive(link_alive)
    );

endmodule

// File: tb/tb_midi_rx_store.sv
// Scoreboard bench for midi_rx_store: stimulus pushes expected FIFO writes,
// a negedge monitor pops and compares data and write cycle.
module tb_midi_rx_store;

    localparam int TIMEOUT = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       midi_clk_locked;
    logic       uart_valid;
    logic [7:0] uart_data;
    logic       uart_frame_err;
    logic       fifo_full;
    logic       fifo_wr_rst_busy;
    logic       fifo_wr;
    logic [7:0] fifo_in;
    logic       link_alive;
    logic       overflow;
    logic       overflow_clr;
    logic [7:0] drop_count;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    midi_rx_store #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .PASS_FE       (0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .midi_clk_locked (midi_clk_locked),
        .uart_valid      (uart_valid),
        .uart_data       (uart_data),
        .uart_frame_err  (uart_frame_err),
        .fifo_full       (fifo_full),
        .fifo_wr_rst_busy(fifo_wr_rst_busy),
        .fifo_wr         (fifo_wr),
        .fifo_in         (fifo_in),
        .link_alive      (link_alive),
        .overflow        (overflow),
        .overflow_clr    (overflow_clr),
        .drop_count      (drop_count)
    );

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, actual, actual, expected, expected, cyc);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected byte and cycle.
    always @(negedge clk) begin
        if (fifo_wr) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_wr: got write of 0x%0h at cycle %0d, expected none",
                         fifo_in, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wr_data", int'(fifo_in), int'(e.data));
                check("wr_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic err, input logic expect_wr);
        @(posedge clk);
        #1;
        uart_valid     = 1'b1;
        uart_data      = d;
        uart_frame_err = err;
        if (expect_wr) sb.push_back('{d, cyc + 1});
        @(posedge clk);
        #1;
        uart_valid     = 1'b0;
        uart_frame_err = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] vec [5];
        int alive_n;

        rst              = 1'b1;
        midi_clk_locked  = 1'b1;
        uart_valid       = 1'b0;
        uart_data        = 8'h00;
        uart_frame_err   = 1'b0;
        fifo_full        = 1'b0;
        fifo_wr_rst_busy = 1'b0;
        overflow_clr     = 1'b0;
        idle(3);
        @(negedge clk);
        check("rst_fifo_wr", fifo_wr, 0);
        check("rst_fifo_in", fifo_in, 0);
        check("rst_link_alive", link_alive, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_count", drop_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Three-byte note-on spaced four cycles apart, then real-time bytes.
        vec = '{8'h90, 8'h3C, 8'h7F, 8'hF8, 8'hFF};
        foreach (vec[i]) begin
            send(vec[i], 1'b0, 1'b1);
            idle(2);
        end
        idle(2);

        // Back-to-back bytes: second arrives in the same cycle as the first write.
        @(posedge clk);
        #1;
        uart_valid = 1'b1;
        uart_data  = 8'hA1;
        sb.push_back('{8'hA1, cyc + 1});
        @(posedge clk);
        #1;
        uart_data = 8'hA2;
        sb.push_back('{8'hA2, cyc + 1});
        @(posedge clk);
        #1;
        uart_valid = 1'b0;
        idle(3);

        // Framing error on an active-sense byte is fully ignored.
        send(8'hFE, 1'b1, 1'b0);
        idle(2);
        @(negedge clk);
        check("fe_frame_err_alive", link_alive, 0);

        // Active sense then silence: alive for exactly TIMEOUT cycles.
        send(8'hFE, 1'b0, 1'b0);
        alive_n = 0;
        for (int i = 0; i < 3 * TIMEOUT; i++) begin
            @(negedge clk);
            if (link_alive) alive_n++;
            else break;
        end
        check("alive_cycles", alive_n, TIMEOUT);
        idle(2);

        // FIFO full: first byte held, next two dropped, then a single write.
        fifo_full = 1'b1;
        send(8'h01, 1'b0, 1'b0);
        send(8'h02, 1'b0, 1'b0);
        send(8'h03, 1'b0, 1'b0);
        @(negedge clk);
        check("full_overflow", overflow, 1);
        check("full_drop_count", drop_count, 2);
        @(posedge clk);
        #1;
        sb.push_back('{8'h01, cyc});
        fifo_full = 1'b0;
        idle(3);
        overflow_clr = 1'b1;
        idle(1);
        overflow_clr = 1'b0;
        @(negedge clk);
        check("clr_overflow", overflow, 0);

        // Clock-lock loss discards the held byte and ignores traffic.
        fifo_full = 1'b1;
        send(8'hFE, 1'b0, 1'b0);
        send(8'h55, 1'b0, 1'b0);
        @(negedge clk);
        check("lock_alive_before", link_alive, 1);
        @(posedge clk);
        #1;
        midi_clk_locked = 1'b0;
        idle(2);
        @(negedge clk);
        check("unlock_alive", link_alive, 0);
        send(8'h66, 1'b0, 1'b0);
        fifo_full = 1'b0;
        idle(3);
        @(negedge clk);
        check("unlock_overflow", overflow, 0);
        check("unlock_drop_count", drop_count, 0);
        @(posedge clk);
        #1;
        midi_clk_locked = 1'b1;
        idle(2);
        send(8'h77, 1'b0, 1'b1);
        idle(3);

        // 300 drops saturate the counter; clear returns both to zero.
        fifo_full = 1'b1;
        send(8'h10, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) send(8'(i), 1'b0, 1'b0);
        @(negedge clk);
        check("sat_drop_count", drop_count, 255);
        check("sat_overflow", overflow, 1);
        @(posedge clk);
        #1;
        overflow_clr = 1'b1;
        idle(1);
        overflow_clr = 1'b0;
        @(negedge clk);
        check("sat_clr_overflow", overflow, 0);
        check("sat_clr_drop_count", drop_count, 0);
        @(posedge clk);
        #1;
        sb.push_back('{8'h10, cyc});
        fifo_full = 1'b0;
        idle(5);

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/midi_rx_store.md
MIDI_RX_STORE -- requirements
Module: midi_rx_store

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 9600000, active-sensing timeout in clk cycles (>=2).
REQ-002 SHALL have parameter PASS_FE, default 0; 1 stores 0xFE bytes in the FIFO as well as using them for keep-alive.
REQ-003 SHALL have port clk  in  1  MIDI system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port midi_clk_locked  in  1  clock-generator lock; low means block disabled.
REQ-006 SHALL have port uart_valid  in  1  one-cycle pulse, received byte present.
REQ-007 SHALL have port uart_data  in  8  received byte, qualified by uart_valid.
REQ-008 SHALL have port uart_frame_err  in  1  stop-bit error on the current byte, qualified by uart_valid.
REQ-009 SHALL have port fifo_full  in  1  write-side full flag.
REQ-010 SHALL have port fifo_wr_rst_busy  in  1  FIFO write side in reset.
REQ-011 SHALL have port fifo_wr  out  1  one-cycle write strobe.
REQ-012 SHALL have port fifo_in  out  8  write data, valid when fifo_wr is high.
REQ-013 SHALL have port link_alive  out  1  high while active sensing is current.
REQ-014 SHALL have port overflow  out  1  sticky, set when a byte is lost.
REQ-015 SHALL have port overflow_clr  in  1  clears overflow and drop_count.
REQ-016 SHALL have port drop_count  out  8  number of lost bytes, saturating at 255.

Function
REQ-017 SHALL implement states S_IDLE, S_HOLD and S_BLOCKED, with a one-byte hold register.
REQ-018 SHALL discard any byte that has uart_frame_err=1: no store, no timer reload, no drop count.
REQ-019 SHALL treat an accepted byte as uart_valid=1, frame_err=0, in S_IDLE or S_HOLD; an accepted byte reloads the timeout counter to 0.
REQ-020 SHALL set link_alive on an accepted 0xFE; with PASS_FE=0 that byte is not stored.
REQ-021 SHALL, in S_IDLE, capture a storable accepted byte into hold and go to S_HOLD.
REQ-022 SHALL, in S_HOLD with fifo_full=0, drive fifo_wr=1 with fifo_in=hold combinationally: a byte in at cycle N gives fifo_wr at cycle N+1.
REQ-023 SHALL, in S_HOLD with fifo_full=1, keep fifo_wr=0 and stay in S_HOLD with hold unchanged.
REQ-024 SHALL, for a storable byte arriving in S_HOLD in the same cycle as fifo_wr=1, load it into hold and remain in S_HOLD with no loss.
REQ-025 SHALL, for a storable byte arriving in S_HOLD while fifo_full=1, drop the new byte, set overflow and increment drop_count (saturating at 255).
REQ-026 SHALL, in S_HOLD after a write with no new byte, return to S_IDLE.
REQ-027 SHALL, when fifo_wr_rst_busy=1 or midi_clk_locked=0 in any state, go to S_BLOCKED next cycle, discard hold and drive fifo_wr=0.
REQ-028 SHALL ignore all uart bytes in S_BLOCKED, with no overflow and no drop count.
REQ-029 SHALL return from S_BLOCKED to S_IDLE the cycle after both blocking conditions clear.
REQ-030 SHALL clear link_alive and hold the timer at 0 while midi_clk_locked=0.
REQ-031 SHALL run the timeout counter (width $clog2(TIMEOUT_CYCLES+1)) only while link_alive=1.
REQ-032 SHALL clear link_alive and stop the counter when the counter reaches TIMEOUT_CYCLES-1 without an accepted byte.
REQ-033 SHALL give overflow_clr priority over a same-cycle overflow event: the flag is cleared and the event is lost.
REQ-034 SHALL pass real-time bytes 0xF8..0xFD and 0xFF as ordinary data, with no MIDI parsing.

Reset
REQ-035 SHALL, on rst, set state S_IDLE, fifo_wr=0, fifo_in=0, hold=0, link_alive=0, overflow=0, drop_count=0 and the counter to 0.
REQ-036 SHALL give rst priority over all other inputs; a byte held when rst asserts is discarded.

Structure
REQ-037 SHALL take the state enum and the constant MIDI_ACTIVE_SENSE=8'hFE from shared package midi_pkg, which the transmit-side fetch block also uses.
REQ-038 SHALL contain one sub-module, midi_alive_timer (counter plus link_alive), parameterised by TIMEOUT_CYCLES, with inputs kick, arm and clear.

Verification
REQ-039 SHALL cover: bytes 0x90, 0x3C, 0x7F spaced 4 cycles, fifo_full=0 -> three fifo_wr pulses in order, each 1 cycle after its uart_valid.
REQ-040 SHALL cover: 0xFE, then no traffic, with TIMEOUT_CYCLES=100 -> no fifo_wr, link_alive=1 for exactly 100 cycles, then 0.
REQ-041 SHALL cover: fifo_full=1, then bytes 0x01, 0x02, 0x03 -> 0x01 held, overflow=1, drop_count=2; full released -> single write of 0x01.
REQ-042 SHALL cover: uart_valid with frame_err=1, data 0xFE -> no write, link_alive stays 0.
REQ-043 SHALL cover: midi_clk_locked dropped while a byte is held -> byte discarded, link_alive=0, bytes ignored; relock -> next byte stored normally.
REQ-044 SHALL cover: 300 drops then overflow_clr -> drop_count reads 255, then overflow=0 and drop_count=0.
